// File: rtl/down_count_monitor_pkg.sv
// Shared state encodings and default widths for down_count_monitor and its saturating counters.
package down_count_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } mon_state_e;

  localparam int unsigned DEF_COUNT_W = 4;
  localparam int unsigned DEF_LAP_W   = 8;
  localparam int unsigned DEF_ERR_W   = 8;
  localparam int unsigned CONSEC_W    = 4;

endpackage

// File: rtl/down_count_monitor_sat_counter.sv
// Up-counter that holds at all-ones; clear takes priority over increment.
module sat_counter
  import down_count_monitor_pkg::*;
#(
  parameter int unsigned W = CONSEC_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/down_count_monitor.sv
// Checks that a sampled count steps down by one each enabled cycle; counts wraps and errors.
// Optional macro DOWN_COUNT_MONITOR_AUTO_RECOVER_EN: leave FAULT after RECOVER_N consecutive good steps.
//
// state | meaning
// IDLE  | no reference value yet; next enabled sample seeds prev
// TRACK | checking each enabled sample against prev-1
// FAULT | MAX_ERR consecutive errors seen; checking continues, fault held high
module down_count_monitor
  import down_count_monitor_pkg::*;
#(
  parameter int unsigned COUNT_W   = DEF_COUNT_W,
  parameter int unsigned LAP_W     = DEF_LAP_W,
  parameter int unsigned ERR_W     = DEF_ERR_W,
  parameter int unsigned MAX_ERR   = 3,
  parameter int unsigned RECOVER_N = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COUNT_W-1:0] count_in,
  input  logic               sample_en,
  input  logic               clear_err,
  output logic               step_ok,
  output logic               stall,
  output logic               err_skip,
  output logic               wrap_pulse,
  output logic [LAP_W-1:0]   lap_count,
  output logic [ERR_W-1:0]   err_count,
  output logic               fault,
  output logic [1:0]         state
);

  if (MAX_ERR < 1 || MAX_ERR > 15 || RECOVER_N < 1 || RECOVER_N > 15) begin : g_bad_param
    $error("down_count_monitor: MAX_ERR and RECOVER_N must be in 1..15");
  end

  mon_state_e         state_q, state_d;
  logic [COUNT_W-1:0] prev_q, prev_d;
  logic [COUNT_W-1:0] expect_val;
  logic [CONSEC_W-1:0] consec;
  logic step_ok_q, stall_q, err_skip_q, wrap_q, fault_q;
  logic active, is_ok, is_stall, is_skip, is_wrap, clr_act, consec_hit, recover;

  assign active     = (state_q != IDLE);
  assign expect_val = prev_q - COUNT_W'(1);
  assign is_ok      = active && sample_en && (count_in == expect_val);
  assign is_stall   = active && sample_en && (count_in == prev_q);
  assign is_skip    = active && sample_en && (count_in != expect_val) && (count_in != prev_q);
  assign is_wrap    = is_ok && (prev_q == '0);
  assign clr_act    = active && clear_err;
  // consec still holds the pre-increment value, so look one error ahead
  assign consec_hit = is_skip && ((32'(consec) + 32'd1) >= MAX_ERR);

  sat_counter #(.W(LAP_W)) u_lap (
    .clk_i(clk), .rst_ni(rst), .inc_i(is_wrap), .clr_i(1'b0), .count_o(lap_count)
  );

  sat_counter #(.W(ERR_W)) u_err (
    .clk_i(clk), .rst_ni(rst), .inc_i(is_skip), .clr_i(clr_act), .count_o(err_count)
  );

  sat_counter #(.W(CONSEC_W)) u_consec (
    .clk_i(clk), .rst_ni(rst), .inc_i(is_skip), .clr_i(clr_act || is_ok), .count_o(consec)
  );

`ifdef DOWN_COUNT_MONITOR_AUTO_RECOVER_EN
  logic [CONSEC_W-1:0] good;
  logic                in_fault;

  assign in_fault = (state_q == FAULT);
  assign recover  = in_fault && is_ok && ((32'(good) + 32'd1) >= RECOVER_N);

  sat_counter #(.W(CONSEC_W)) u_good (
    .clk_i(clk), .rst_ni(rst), .inc_i(in_fault && is_ok),
    .clr_i(!in_fault || is_skip || recover), .count_o(good)
  );
`else
  assign recover = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    case (state_q)
      IDLE:    if (sample_en) state_d = TRACK;
      TRACK:   if (consec_hit) state_d = FAULT;
      FAULT:   if (recover) state_d = TRACK;
      default: state_d = IDLE;
    endcase
    if (clr_act) state_d = TRACK;
    if (sample_en) prev_d = count_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      step_ok_q  <= 1'b0;
      stall_q    <= 1'b0;
      err_skip_q <= 1'b0;
      wrap_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      step_ok_q  <= is_ok;
      stall_q    <= is_stall;
      err_skip_q <= is_skip;
      wrap_q     <= is_wrap;
      fault_q    <= (state_d == FAULT);
    end
  end

  assign step_ok    = step_ok_q;
  assign stall      = stall_q;
  assign err_skip   = err_skip_q;
  assign wrap_pulse = wrap_q;
  assign fault      = fault_q;
  assign state      = state_q;

endmodule

// File: tb/tb_down_count_monitor.sv
// Randomised and directed bench for down_count_monitor against a behavioural model.
module tb_down_count_monitor;

  localparam int MAX_ERR   = 3;
  localparam int RECOVER_N = 4;
`ifdef DOWN_COUNT_MONITOR_AUTO_RECOVER_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] count_in = '0;
  logic       sample_en = 1'b0;
  logic       clear_err = 1'b0;
  logic       step_ok, stall, err_skip, wrap_pulse, fault;
  logic [7:0] lap_count, err_count;
  logic [1:0] state;

  down_count_monitor #(
    .COUNT_W(4), .LAP_W(8), .ERR_W(8), .MAX_ERR(MAX_ERR), .RECOVER_N(RECOVER_N)
  ) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .sample_en(sample_en),
    .clear_err(clear_err), .step_ok(step_ok), .stall(stall), .err_skip(err_skip),
    .wrap_pulse(wrap_pulse), .lap_count(lap_count), .err_count(err_count),
    .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model: state 0/1/2 = idle/track/fault
  int m_state, m_prev, m_lap, m_err, m_consec, m_good;
  int e_ok, e_st, e_sk, e_wr;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_prev = 0; m_lap = 0; m_err = 0; m_consec = 0; m_good = 0;
    e_ok = 0; e_st = 0; e_sk = 0; e_wr = 0;
  endtask

  task automatic model_step(input int c, input bit e, input bit cl);
    e_ok = 0; e_st = 0; e_sk = 0; e_wr = 0;
    if (m_state == 0) begin
      if (e) begin
        m_prev  = c;
        m_state = 1;
      end
      return;
    end
    if (e) begin
      if (c == (m_prev + 15) % 16) begin
        e_ok = 1;
        m_consec = 0;
        if (m_prev == 0) begin
          e_wr = 1;
          if (m_lap < 255) m_lap++;
        end
        if (m_state == 2) begin
          m_good++;
          if (AUTO && m_good >= RECOVER_N) m_state = 1;
        end
      end else if (c == m_prev) begin
        e_st = 1;
      end else begin
        e_sk = 1;
        m_good = 0;
        if (m_err < 255) m_err++;
        if (m_consec < 15) m_consec++;
        if (m_state == 1 && m_consec >= MAX_ERR) m_state = 2;
      end
      m_prev = c;
    end
    if (cl) begin
      m_err = 0; m_consec = 0; m_state = 1;
    end
    if (m_state != 2) m_good = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ok"},    int'(step_ok),    e_ok);
    chk({tag, ".stall"}, int'(stall),      e_st);
    chk({tag, ".skip"},  int'(err_skip),   e_sk);
    chk({tag, ".wrap"},  int'(wrap_pulse), e_wr);
    chk({tag, ".lap"},   int'(lap_count),  m_lap);
    chk({tag, ".errc"},  int'(err_count),  m_err);
    chk({tag, ".fault"}, int'(fault),      (m_state == 2) ? 1 : 0);
    chk({tag, ".state"}, int'(state),      m_state);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic cyc(input string tag, input int c, input bit e, input bit cl);
    count_in  = 4'(c);
    sample_en = e;
    clear_err = cl;
    @(posedge clk);
    #1;
    model_step(c, e, cl);
    check_all(tag);
  endtask

  task automatic do_reset();
    sample_en = 1'b0;
    clear_err = 1'b0;
    rst = 1'b0;
    #2;
    model_reset();
    check_all("rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  int drv;
  int nstall;

  initial begin
    model_reset();
    #2;
    check_all("por");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // full lap sequence with two wraps
    cyc("t1", 0, 1, 0);
    for (int v = 15; v >= 0; v--) cyc("t1", v, 1, 0);
    cyc("t1", 15, 1, 0);
    chk("t1.lap2", int'(lap_count), 2);
    chk("t1.err0", int'(err_count), 0);
    chk("t1.track", int'(state), 1);

    // stalls
    nstall = 0;
    begin
      int seq[5] = '{9, 8, 8, 8, 7};
      foreach (seq[i]) begin
        cyc("t2", seq[i], 1, 0);
        if (i > 0 && stall) nstall++;
      end
    end
    chk("t2.nstall", nstall, 2);

    // escalation to FAULT
    do_reset();
    begin
      int seq[4] = '{9, 5, 2, 11};
      foreach (seq[i]) cyc("t3", seq[i], 1, 0);
    end
    chk("t3.fault", int'(fault), 1);
    chk("t3.skip", int'(err_skip), 1);
    chk("t3.errc", int'(err_count), 3);

    // clear_err beats a simultaneous bad sample
    cyc("t4", 0, 1, 1);
    chk("t4.errc", int'(err_count), 0);
    chk("t4.state", int'(state), 1);
    chk("t4.lap", int'(lap_count), 0);

    // reset mid-stream
    cyc("t5", 15, 1, 0);
    cyc("t5", 14, 1, 0);
    do_reset();
    chk("t5.idle", int'(state), 0);
    cyc("t5", 3, 1, 0);
    chk("t5.first", int'(step_ok | stall | err_skip | wrap_pulse), 0);
    cyc("t5", 2, 1, 0);
    chk("t5.ok", int'(step_ok), 1);

    // recovery from FAULT
    do_reset();
    begin
      int seq[10] = '{9, 5, 2, 11, 7, 6, 6, 5, 4, 3};
      foreach (seq[i]) begin
        cyc("t6", seq[i], 1, 0);
        if (i == 8) chk("t6.still", int'(state), 2);
      end
    end
    chk("t6.end", int'(state), AUTO ? 1 : 2);

    // randomised traffic
    do_reset();
    drv = 0;
    for (int n = 0; n < 2000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 84) drv = (drv + 15) % 16;
      else if (r < 92) drv = drv;
      else drv = $urandom_range(0, 15);
      if ($urandom_range(0, 299) == 0) do_reset();
      cyc("rnd", drv, ($urandom_range(0, 9) < 8), ($urandom_range(0, 99) < 3));
    end

    // lap counter saturation
    do_reset();
    drv = 0;
    for (int n = 0; n < 16 * 260; n++) begin
      cyc("lsat", drv, 1, 0);
      drv = (drv + 15) % 16;
    end
    chk("lsat.lap", int'(lap_count), 255);

    // error counter saturation
    for (int n = 0; n < 270; n++) begin
      drv = (drv + 2) % 16;
      cyc("esat", drv, 1, 0);
    end
    chk("esat.errc", int'(err_count), 255);
    cyc("esat", drv, 1, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
